// File: rtl/fx_cmd_master.sv
// fx_cmd_master: host byte-stream to fx register bus master (one write or read per command, one response byte each)
// Ports:
//   clk_sys, rst_n           system clock, async active-low reset
//   i_rx_data/i_rx_vld/o_rx_rdy  command byte stream in
//   o_tx_data/o_tx_vld/i_tx_rdy  response byte out (ACK for write, data for read)
//   o_fx_waddr/o_fx_data/o_fx_wr write port of the fx bus
//   o_fx_raddr/o_fx_rd/i_fx_q    read port of the fx bus, data one cycle after o_fx_rd
//   o_cmd_err                1-cycle pulse on bad opcode or inter-byte timeout
module fx_cmd_master #(
    parameter logic [7:0] OP_WR    = 8'h57,
    parameter logic [7:0] OP_RD    = 8'h52,
    parameter logic [7:0] ACK_BYTE = 8'hAA,
    parameter int         TO_CYC   = 50000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_vld,
    output logic        o_rx_rdy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_vld,
    input  logic        i_tx_rdy,
    output logic [15:0] o_fx_waddr,
    output logic [7:0]  o_fx_data,
    output logic        o_fx_wr,
    output logic [15:0] o_fx_raddr,
    output logic        o_fx_rd,
    input  logic [7:0]  i_fx_q,
    output logic        o_cmd_err
);
    localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);
    typedef enum logic [2:0] {IDLE, AH, AL, DAT, WR, RD, RWAIT, RESP} state_t;
    state_t      r_state;
    logic        r_is_wr;
    logic [15:0] r_addr;
    logic [15:0] r_cnt;
    logic [7:0]  r_tx_data;
    logic        r_tx_vld;
    logic [15:0] r_fx_waddr;
    logic [7:0]  r_fx_data;
    logic        r_fx_wr;
    logic [15:0] r_fx_raddr;
    logic        r_fx_rd;
    logic        r_cmd_err;
    logic        w_acc;
    logic        w_to;
    assign o_rx_rdy   = (r_state == IDLE) || (r_state == AH) || (r_state == AL) || (r_state == DAT);
    assign w_acc      = i_rx_vld & o_rx_rdy;
    assign w_to       = r_cnt == TO_LAST;
    assign o_tx_data  = r_tx_data;
    assign o_tx_vld   = r_tx_vld;
    assign o_fx_waddr = r_fx_waddr;
    assign o_fx_data  = r_fx_data;
    assign o_fx_wr    = r_fx_wr;
    assign o_fx_raddr = r_fx_raddr;
    assign o_fx_rd    = r_fx_rd;
    assign o_cmd_err  = r_cmd_err;
    // Bus outputs are loaded on the edge that accepts the last byte, so the
    // strobe appears in the WR/RD state cycle with no combinational path.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_tx_vld   <= 1'b0;
            r_fx_waddr <= '0;
            r_fx_data  <= '0;
            r_fx_wr    <= 1'b0;
            r_fx_raddr <= '0;
            r_fx_rd    <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_fx_wr   <= 1'b0;
            r_fx_rd   <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_acc) begin
                        if (i_rx_data == OP_WR) begin
                            r_is_wr <= 1'b1;
                            r_state <= AH;
                        end else if (i_rx_data == OP_RD) begin
                            r_is_wr <= 1'b0;
                            r_state <= AH;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                AH, AL, DAT: begin
                    // An arriving byte takes priority over an expiring timeout.
                    if (w_acc) begin
                        r_cnt <= '0;
                        case (r_state)
                            AH: begin
                                r_addr[15:8] <= i_rx_data;
                                r_state      <= AL;
                            end
                            AL: begin
                                r_addr[7:0] <= i_rx_data;
                                if (r_is_wr) begin
                                    r_state <= DAT;
                                end else begin
                                    r_fx_raddr <= {r_addr[15:8], i_rx_data};
                                    r_fx_rd    <= 1'b1;
                                    r_state    <= RD;
                                end
                            end
                            default: begin
                                r_fx_waddr <= r_addr;
                                r_fx_data  <= i_rx_data;
                                r_fx_wr    <= 1'b1;
                                r_state    <= WR;
                            end
                        endcase
                    end else if (w_to) begin
                        r_cnt     <= '0;
                        r_cmd_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                WR: begin
                    r_tx_data <= ACK_BYTE;
                    r_tx_vld  <= 1'b1;
                    r_state   <= RESP;
                end
                RD: r_state <= RWAIT;
                RWAIT: begin
                    // Slave data is registered, valid the cycle after o_fx_rd.
                    r_tx_data <= i_fx_q;
                    r_tx_vld  <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (i_tx_rdy) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fx_cmd_master.sv
// tb_fx_cmd_master: directed bench for fx_cmd_master with a registered slave model
module tb_fx_cmd_master;
    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [15:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_wr;
    logic [15:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic        cmd_err;
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int rd_cnt  = 0;
    int err_cnt = 0;
    int tx_cnt  = 0;
    bit both_hi = 1'b0;

    always #5 clk_sys = ~clk_sys;

    fx_cmd_master #(.TO_CYC(16)) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_vld   (rx_vld),
        .o_rx_rdy   (rx_rdy),
        .o_tx_data  (tx_data),
        .o_tx_vld   (tx_vld),
        .i_tx_rdy   (tx_rdy),
        .o_fx_waddr (fx_waddr),
        .o_fx_data  (fx_data),
        .o_fx_wr    (fx_wr),
        .o_fx_raddr (fx_raddr),
        .o_fx_rd    (fx_rd),
        .i_fx_q     (fx_q),
        .o_cmd_err  (cmd_err)
    );

    // Slave model: registered read data equal to the low address byte.
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) fx_q <= 8'h00;
        else fx_q <= fx_rd ? fx_raddr[7:0] : 8'h00;
    end

    always @(posedge clk_sys) begin
        if (fx_wr) wr_cnt++;
        if (fx_rd) rd_cnt++;
        if (cmd_err) err_cnt++;
        if (tx_vld && tx_rdy) tx_cnt++;
        if (fx_wr && fx_rd) both_hi = 1'b1;
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk_sys);
        rx_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; tx_rdy = 1'b1;
        #1;
        n_tests++;
        if ({fx_wr, fx_rd, tx_vld, cmd_err, fx_waddr, fx_raddr, fx_data, tx_data} !== 44'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got wr=%b rd=%b tv=%b err=%b wa=%h ra=%h d=%h td=%h want all 0", fx_wr, fx_rd, tx_vld, cmd_err, fx_waddr, fx_raddr, fx_data, tx_data);
        end
        n_tests++;
        if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rx_rdy got %b want 1", rx_rdy); end
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        send(8'h57); send(8'h03); send(8'h81); send(8'h5C);
        n_tests++;
        if ({fx_wr, fx_waddr, fx_data} !== {1'b1, 16'h0381, 8'h5C}) begin
            n_fail++;
            $display("FAIL write_strobe got wr=%b wa=%h d=%h want wr=1 wa=0381 d=5c", fx_wr, fx_waddr, fx_data);
        end
        idle(1);
        n_tests++;
        if ({tx_vld, tx_data, fx_wr} !== {1'b1, 8'hAA, 1'b0}) begin
            n_fail++;
            $display("FAIL write_ack got tv=%b td=%h wr=%b want tv=1 td=aa wr=0", tx_vld, tx_data, fx_wr);
        end
        idle(1);
        n_tests++;
        if ({tx_vld, rx_rdy, fx_waddr, fx_data} !== {1'b0, 1'b1, 16'h0381, 8'h5C} || wr_cnt - w0 != 1) begin
            n_fail++;
            $display("FAIL write_done got tv=%b rr=%b wa=%h d=%h pulses=%0d want tv=0 rr=1 wa=0381 d=5c pulses=1", tx_vld, rx_rdy, fx_waddr, fx_data, wr_cnt - w0);
        end
        idle(2);
    endtask

    task automatic test_read();
        int r0 = rd_cnt;
        send(8'h52); send(8'h03); send(8'h80);
        n_tests++;
        if ({fx_rd, fx_wr, fx_raddr} !== {1'b1, 1'b0, 16'h0380}) begin
            n_fail++;
            $display("FAIL read_strobe got rd=%b wr=%b ra=%h want rd=1 wr=0 ra=0380", fx_rd, fx_wr, fx_raddr);
        end
        idle(1);
        n_tests++;
        if ({fx_rd, tx_vld} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_wait got rd=%b tv=%b want 0 0", fx_rd, tx_vld);
        end
        idle(1);
        n_tests++;
        if ({tx_vld, tx_data, fx_raddr, fx_waddr} !== {1'b1, 8'h80, 16'h0380, 16'h0381} || rd_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL read_resp got tv=%b td=%h ra=%h wa=%h pulses=%0d want tv=1 td=80 ra=0380 wa=0381 pulses=1", tx_vld, tx_data, fx_raddr, fx_waddr, rd_cnt - r0);
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        int t0;
        bit ok = 1'b1;
        tx_rdy = 1'b0;
        send(8'h52); send(8'h0A); send(8'h5C);
        idle(2);
        for (int i = 0; i < 20; i++) begin
            if ({tx_vld, tx_data, rx_rdy} !== {1'b1, 8'h5C, 1'b0}) ok = 1'b0;
            idle(1);
        end
        n_tests++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold got tv=%b td=%h rr=%b want held tv=1 td=5c rr=0 for 20 cycles", tx_vld, tx_data, rx_rdy);
        end
        t0 = tx_cnt;
        tx_rdy = 1'b1;
        idle(1);
        n_tests++;
        if ({tx_vld, rx_rdy} !== 2'b01 || tx_cnt - t0 != 1) begin
            n_fail++;
            $display("FAIL bp_release got tv=%b rr=%b xfers=%0d want tv=0 rr=1 xfers=1", tx_vld, rx_rdy, tx_cnt - t0);
        end
        idle(2);
    endtask

    task automatic test_bad_opcode();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        send(8'h33);
        n_tests++;
        if ({cmd_err, rx_rdy, fx_wr, fx_rd} !== 4'b1100) begin
            n_fail++;
            $display("FAIL badop_err got err=%b rr=%b wr=%b rd=%b want 1 1 0 0", cmd_err, rx_rdy, fx_wr, fx_rd);
        end
        idle(1);
        n_tests++;
        if (cmd_err !== 1'b0 || wr_cnt != w0 || rd_cnt != r0) begin
            n_fail++;
            $display("FAIL badop_after got err=%b wr_pulses=%0d rd_pulses=%0d want err=0 and 0 pulses", cmd_err, wr_cnt - w0, rd_cnt - r0);
        end
        send(8'h52); send(8'h00); send(8'h00);
        n_tests++;
        if ({fx_rd, fx_raddr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL badop_read got rd=%b ra=%h want rd=1 ra=0000", fx_rd, fx_raddr);
        end
        idle(2);
        n_tests++;
        if ({tx_vld, tx_data} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL badop_resp got tv=%b td=%h want tv=1 td=00", tx_vld, tx_data);
        end
        idle(3);
    endtask

    task automatic test_timeout();
        int w0 = wr_cnt;
        int e0;
        bit quiet = 1'b1;
        send(8'h57); send(8'h01);
        for (int i = 0; i < 16; i++) begin
            if (cmd_err !== 1'b0) quiet = 1'b0;
            idle(1);
        end
        n_tests++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL to_early got early cmd_err want none for 16 cycles"); end
        n_tests++;
        if ({cmd_err, rx_rdy} !== 2'b11 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL to_fire got err=%b rr=%b wr_pulses=%0d want err=1 rr=1 pulses=0", cmd_err, rx_rdy, wr_cnt - w0);
        end
        send(8'h52); send(8'h00); send(8'h04);
        n_tests++;
        if ({fx_rd, fx_raddr} !== {1'b1, 16'h0004}) begin
            n_fail++;
            $display("FAIL to_recover got rd=%b ra=%h want rd=1 ra=0004", fx_rd, fx_raddr);
        end
        idle(2);
        n_tests++;
        if ({tx_vld, tx_data} !== {1'b1, 8'h04}) begin
            n_fail++;
            $display("FAIL to_recover_resp got tv=%b td=%h want tv=1 td=04", tx_vld, tx_data);
        end
        idle(3);
        e0 = err_cnt;
        send(8'h57); send(8'h01);
        idle(15);
        send(8'h02);
        n_tests++;
        if ({cmd_err, rx_rdy} !== 2'b01 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL to_edge_byte got err=%b rr=%b errs=%0d want err=0 rr=1 errs=0", cmd_err, rx_rdy, err_cnt - e0);
        end
        send(8'h77);
        n_tests++;
        if ({fx_wr, fx_waddr, fx_data} !== {1'b1, 16'h0102, 8'h77} || err_cnt != e0) begin
            n_fail++;
            $display("FAIL to_edge_write got wr=%b wa=%h d=%h errs=%0d want wr=1 wa=0102 d=77 errs=0", fx_wr, fx_waddr, fx_data, err_cnt - e0);
        end
        idle(3);
    endtask

    task automatic test_reset_mid();
        int w0;
        send(8'h57); send(8'h12); send(8'h34);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({fx_wr, fx_rd, tx_vld, cmd_err, fx_waddr, fx_raddr, fx_data, tx_data, rx_rdy} !== 45'h1) begin
            n_fail++;
            $display("FAIL midrst_outputs got wr=%b rd=%b tv=%b err=%b wa=%h ra=%h d=%h td=%h rr=%b want all 0, rr=1", fx_wr, fx_rd, tx_vld, cmd_err, fx_waddr, fx_raddr, fx_data, tx_data, rx_rdy);
        end
        idle(2);
        rst_n = 1'b1;
        w0 = wr_cnt;
        idle(3);
        n_tests++;
        if (fx_wr !== 1'b0 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL midrst_stale got wr=%b pulses=%0d want wr=0 pulses=0", fx_wr, wr_cnt - w0);
        end
        send(8'h57); send(8'h02); send(8'h10); send(8'h99);
        n_tests++;
        if ({fx_wr, fx_waddr, fx_data} !== {1'b1, 16'h0210, 8'h99}) begin
            n_fail++;
            $display("FAIL midrst_write got wr=%b wa=%h d=%h want wr=1 wa=0210 d=99", fx_wr, fx_waddr, fx_data);
        end
        idle(1);
        n_tests++;
        if ({tx_vld, tx_data} !== {1'b1, 8'hAA}) begin
            n_fail++;
            $display("FAIL midrst_ack got tv=%b td=%h want tv=1 td=aa", tx_vld, tx_data);
        end
        idle(3);
    endtask

    task automatic test_totals();
        n_tests++;
        if (wr_cnt != 3 || rd_cnt != 4 || err_cnt != 2) begin
            n_fail++;
            $display("FAIL totals got wr=%0d rd=%0d err=%0d want wr=3 rd=4 err=2", wr_cnt, rd_cnt, err_cnt);
        end
        n_tests++;
        if (both_hi !== 1'b0) begin n_fail++; $display("FAIL wr_rd_overlap got overlap=1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_bad_opcode();
        test_timeout();
        test_reset_mid();
        test_totals();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
